req_issuer: RTL and testbench
=============================

Name: req_issuer

Overview:
- Upstream requester for the req/gnt arbitration stage.
- Buffers incoming commands in a small FIFO and presents one at a time on req.
- Holds req until gnt or a timeout, then retires the command with a status result.
- Keeps saturating grant/timeout counters and a sticky spurious-grant flag for debug and assertions.

Parameters:
- DEPTH, 4, command FIFO entries (power of two, >= 2).
- DW, 8, command payload width.
- TIMEOUT, 8, maximum cycles req stays high waiting for gnt (>= 2).
- CNT_W, 8, width of the statistics counters.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_data  in  DW  command payload.
- req  out  1  request to the granting stage (registered).
- gnt  in  1  grant from the granting stage.
- done_valid  out  1  one-cycle pulse: command retired.
- done_data  out  DW  payload of the retired command.
- done_err  out  1  qualifies done_valid: 1 = timed out, 0 = granted.
- grant_cnt  out  CNT_W  saturating count of granted commands.
- timeout_cnt  out  CNT_W  saturating count of timed-out commands.
- spurious  out  1  sticky: gnt seen while req low.
- busy  out  1  FIFO non-empty or FSM not in IDLE.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - req=0, done_valid=0, done_data=0, done_err=0.
  - Counters=0, spurious=0, FIFO empty (cmd_ready=1), FSM=IDLE.
  - Reset mid-request drops req immediately; the in-flight command is discarded with no done pulse.
- FIFO:
  - Push on cmd_valid && cmd_ready. Pop only on retire.
  - Push and pop in the same cycle are legal when not full; occupancy is unchanged.
  - cmd_valid while full is ignored and the data is not captured.
  - Pointers wrap modulo DEPTH. A separate count register distinguishes full from empty.
- FSM (IDLE, REQ, COOL):
  - IDLE: if FIFO non-empty, go REQ and set req=1 at the same edge, with the wait counter cleared to 0.
  - IDLE with FIFO empty: stay in IDLE, req=0.
  - REQ: req held 1. Head entry must not change while in REQ.
  - REQ, each edge:
    - If gnt=1: pop; done_valid=1, done_err=0, done_data=head; grant_cnt+1; req=0; go COOL.
    - Else if wait==TIMEOUT-1: pop; done_valid=1, done_err=1, done_data=head; timeout_cnt+1; req=0; go COOL.
    - Else: wait+1.
    - gnt on the final wait cycle counts as a grant (gnt takes priority over timeout).
  - COOL: req=0 for exactly one cycle, then IDLE. req therefore has at least 1 low cycle between requests.
- Latency:
  - Push at edge N into an empty, idle block gives req=1 after edge N+1.
  - gnt sampled high at edge M gives done_valid=1 and req=0 after edge M.
  - Back-to-back commands: req high periods are separated by 2 low cycles (COOL + IDLE).
- Counters and flags:
  - Counters stop at 2^CNT_W-1.
  - spurious sets when gnt=1 at an edge in IDLE or COOL; cleared only by reset.
  - gnt in IDLE/COOL has no other effect.
- done_valid is high only in the cycle after retire; otherwise 0. done_data/done_err hold their last values.

Test Plan:
- Single command 0xA5, gnt raised 3 cycles after req -> req high exactly 3 cycles; done_valid pulse with done_data=0xA5, done_err=0; grant_cnt=1.
- Single command 0x3C, gnt never asserted, TIMEOUT=8 -> req high 8 cycles then 0; done_err=1, done_data=0x3C; timeout_cnt=1, grant_cnt=0.
- Push 5 commands 0x01..0x05 back-to-back with DEPTH=4 while gnt held 0:
  - cmd_ready drops after the 4th push; the 5th is not captured.
  - Then hold gnt=1: four done pulses in order 0x01..0x04, req low 2 cycles between each.
- gnt first asserted on wait cycle 7 (TIMEOUT-1) -> granted, done_err=0; gnt at cycle 8 after a timeout retire -> spurious=1.
- gnt pulse while idle and empty -> spurious=1, req stays 0, no done pulse, counters unchanged.
- rst_n asserted low mid-REQ with 2 entries queued -> req=0 immediately, FIFO empty, counters 0, no done_valid; after release the block stays idle.

Source files
------------

// File: rtl/req_issuer.sv
// Command FIFO feeding a req/gnt handshake with a per-command timeout.
// Each command retires with a done pulse flagged as granted or timed out.
module req_issuer #(
    parameter int DEPTH   = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [DW-1:0]    cmd_data,
    output logic             req,
    input  logic             gnt,
    output logic             done_valid,
    output logic [DW-1:0]    done_data,
    output logic             done_err,
    output logic [CNT_W-1:0] grant_cnt,
    output logic [CNT_W-1:0] timeout_cnt,
    output logic             spurious,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_COOL = 2'd2;

    logic [DW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic [1:0]       state_q, state_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic             req_q, req_d;
    logic             done_valid_q, done_valid_d;
    logic [DW-1:0]    done_data_q, done_data_d;
    logic             done_err_q, done_err_d;
    logic [CNT_W-1:0] grant_cnt_q, grant_cnt_d;
    logic [CNT_W-1:0] timeout_cnt_q, timeout_cnt_d;
    logic             spurious_q, spurious_d;
    logic             push, pop;
    logic [DW-1:0]    head;

    assign cmd_ready = (count_q != FULL_CNT);
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem_q[rd_ptr_q];

    // Payload storage needs no reset; count_q alone says which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_data;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        req_d         = req_q;
        done_valid_d  = 1'b0;
        done_data_d   = done_data_q;
        done_err_d    = done_err_q;
        grant_cnt_d   = grant_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        spurious_d    = spurious_q | (gnt && (state_q != ST_REQ));
        pop           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_d = 1'b0;
                if (count_q != '0) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    wait_d  = '0;
                end
            end
            ST_REQ: begin
                // gnt wins over a timeout landing on the same edge
                if (gnt) begin
                    pop          = 1'b1;
                    done_valid_d = 1'b1;
                    done_err_d   = 1'b0;
                    done_data_d  = head;
                    if (grant_cnt_q != '1) begin
                        grant_cnt_d = grant_cnt_q + CNT_W'(1);
                    end
                    req_d   = 1'b0;
                    state_d = ST_COOL;
                end else if (wait_q == WAIT_LAST) begin
                    pop          = 1'b1;
                    done_valid_d = 1'b1;
                    done_err_d   = 1'b1;
                    done_data_d  = head;
                    if (timeout_cnt_q != '1) begin
                        timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
                    end
                    req_d   = 1'b0;
                    state_d = ST_COOL;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            ST_COOL: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= ST_IDLE;
            wait_q        <= '0;
            req_q         <= 1'b0;
            done_valid_q  <= 1'b0;
            done_data_q   <= '0;
            done_err_q    <= 1'b0;
            grant_cnt_q   <= '0;
            timeout_cnt_q <= '0;
            spurious_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q       <= count_d;
            state_q       <= state_d;
            wait_q        <= wait_d;
            req_q         <= req_d;
            done_valid_q  <= done_valid_d;
            done_data_q   <= done_data_d;
            done_err_q    <= done_err_d;
            grant_cnt_q   <= grant_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            spurious_q    <= spurious_d;
        end
    end

    assign req         = req_q;
    assign done_valid  = done_valid_q;
    assign done_data   = done_data_q;
    assign done_err    = done_err_q;
    assign grant_cnt   = grant_cnt_q;
    assign timeout_cnt = timeout_cnt_q;
    assign spurious    = spurious_q;
    assign busy        = (count_q != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_req_issuer.sv
// Directed bench for req_issuer: expected retirements go into a queue and a
// monitor pops them on every done pulse; the stimulus thread checks timing.
module tb_req_issuer;

    localparam int DEPTH   = 4;
    localparam int DW      = 8;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 8;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [DW-1:0]    cmd_data;
    logic             req;
    logic             gnt;
    logic             done_valid;
    logic [DW-1:0]    done_data;
    logic             done_err;
    logic [CNT_W-1:0] grant_cnt;
    logic [CNT_W-1:0] timeout_cnt;
    logic             spurious;
    logic             busy;

    req_issuer #(
        .DEPTH  (DEPTH),
        .DW     (DW),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_data   (cmd_data),
        .req        (req),
        .gnt        (gnt),
        .done_valid (done_valid),
        .done_data  (done_data),
        .done_err   (done_err),
        .grant_cnt  (grant_cnt),
        .timeout_cnt(timeout_cnt),
        .spurious   (spurious),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW:0] exp_q [$];  // {err, data}
    int hi_run  = 0;
    int last_hi = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [DW:0] e;
        if (rst_n && done_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got data=%0h err=%0b, required no done pulse",
                         done_data, done_err);
            end else begin
                e = exp_q.pop_front();
                check("done_data", 32'(done_data), 32'(e[DW-1:0]));
                check("done_err", 32'(done_err), 32'(e[DW]));
            end
        end
    end

    // Length of the most recent completed req-high period
    always @(negedge clk) begin
        if (!rst_n) begin
            hi_run = 0;
        end else if (req) begin
            hi_run++;
        end else if (hi_run != 0) begin
            last_hi = hi_run;
            hi_run  = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        gnt       = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("sb_empty_at_reset", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic push_one(input logic [DW-1:0] d);
        cmd_valid = 1'b1;
        cmd_data  = d;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_req(input logic lvl, input string name, input int bound);
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            #1;
            if (req == lvl) break;
        end
        check(name, 32'(req), 32'(lvl));
    endtask

    initial begin
        int lo;
        int hi_seen;

        // Reset state
        do_reset();
        check("rst_req", 32'(req), 32'd0);
        check("rst_done_valid", 32'(done_valid), 32'd0);
        check("rst_done_data", 32'(done_data), 32'd0);
        check("rst_done_err", 32'(done_err), 32'd0);
        check("rst_grant_cnt", 32'(grant_cnt), 32'd0);
        check("rst_timeout_cnt", 32'(timeout_cnt), 32'd0);
        check("rst_spurious", 32'(spurious), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);

        // Grant three cycles after req
        exp_q.push_back({1'b0, 8'hA5});
        push_one(8'hA5);
        wait_req(1'b1, "a_req_rise", 10);
        repeat (2) @(posedge clk);
        #1 gnt = 1'b1;
        @(posedge clk);
        #1 gnt = 1'b0;
        check("a_req_drop", 32'(req), 32'd0);
        check("a_done_valid", 32'(done_valid), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("a_req_high_len", 32'(last_hi), 32'd3);
        check("a_grant_cnt", 32'(grant_cnt), 32'd1);
        check("a_timeout_cnt", 32'(timeout_cnt), 32'd0);
        check("a_spurious", 32'(spurious), 32'd0);

        // Timeout with no grant
        do_reset();
        exp_q.push_back({1'b1, 8'h3C});
        push_one(8'h3C);
        wait_req(1'b1, "b_req_rise", 10);
        wait_req(1'b0, "b_req_fall", 12);
        check("b_done_err", 32'(done_err), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("b_req_high_len", 32'(last_hi), 32'd8);
        check("b_timeout_cnt", 32'(timeout_cnt), 32'd1);
        check("b_grant_cnt", 32'(grant_cnt), 32'd0);

        // Fill past DEPTH, then drain with gnt held high
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            cmd_valid = 1'b1;
            cmd_data  = DW'(i);
            if (i <= DEPTH) exp_q.push_back({1'b0, DW'(i)});
            @(posedge clk);
            #1;
            if (i == 4) check("c_ready_full", 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        gnt = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_req(1'b0, "c_req_fall", 12);
            lo = 0;
            while (req == 1'b0 && lo < 10) begin
                @(posedge clk);
                #1 lo++;
            end
            check("c_gap_len", 32'(lo), 32'd2);
        end
        wait_req(1'b0, "c_last_fall", 12);
        for (int i = 0; i < 10 && busy; i++) begin
            @(posedge clk);
            #1;
        end
        gnt = 1'b0;
        check("c_idle", 32'(busy), 32'd0);
        check("c_grant_cnt", 32'(grant_cnt), 32'd4);
        check("c_sb_drained", 32'(exp_q.size()), 32'd0);

        // Grant on the last wait cycle, then gnt during COOL
        do_reset();
        exp_q.push_back({1'b0, 8'h5A});
        push_one(8'h5A);
        wait_req(1'b1, "d_req_rise", 10);
        repeat (7) @(posedge clk);
        #1 gnt = 1'b1;
        @(posedge clk);
        #1 gnt = 1'b0;
        check("d_req_drop", 32'(req), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("d_req_high_len", 32'(last_hi), 32'd8);
        check("d_grant_cnt", 32'(grant_cnt), 32'd1);
        check("d_timeout_cnt0", 32'(timeout_cnt), 32'd0);
        check("d_spurious0", 32'(spurious), 32'd0);
        exp_q.push_back({1'b1, 8'h77});
        push_one(8'h77);
        wait_req(1'b1, "d2_req_rise", 10);
        wait_req(1'b0, "d2_req_fall", 12);
        gnt = 1'b1;
        @(posedge clk);
        #1 gnt = 1'b0;
        check("d2_spurious", 32'(spurious), 32'd1);
        check("d2_timeout_cnt", 32'(timeout_cnt), 32'd1);
        check("d2_grant_cnt", 32'(grant_cnt), 32'd1);

        // gnt while idle and empty
        do_reset();
        repeat (2) @(posedge clk);
        #1 gnt = 1'b1;
        @(posedge clk);
        #1 gnt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("e_spurious", 32'(spurious), 32'd1);
        check("e_req", 32'(req), 32'd0);
        check("e_grant_cnt", 32'(grant_cnt), 32'd0);
        check("e_timeout_cnt", 32'(timeout_cnt), 32'd0);
        check("e_busy", 32'(busy), 32'd0);

        // Reset mid-request with two entries queued
        do_reset();
        cmd_valid = 1'b1;
        cmd_data  = 8'h11;
        @(posedge clk);
        #1 cmd_data = 8'h22;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        check("f_req_before_rst", 32'(req), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("f_req_in_rst", 32'(req), 32'd0);
        check("f_ready_in_rst", 32'(cmd_ready), 32'd1);
        check("f_busy_in_rst", 32'(busy), 32'd0);
        check("f_done_in_rst", 32'(done_valid), 32'd0);
        check("f_grant_in_rst", 32'(grant_cnt), 32'd0);
        check("f_timeout_in_rst", 32'(timeout_cnt), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        hi_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (req) hi_seen++;
        end
        check("f_req_after_rst", 32'(hi_seen), 32'd0);
        check("f_busy_after_rst", 32'(busy), 32'd0);
        check("final_sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
